// File: rtl/gmii_tx_frame_scheduler.sv
// GMII transmit frame scheduler: emits bursts of Ethernet test frames
// (preamble, SFD, header, counting payload, CRC-32 FCS, inter-frame gap).
module gmii_tx_frame_scheduler #(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500,
  parameter int MIN_GAP      = 12
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        SendEn,
  input  logic        Stop,
  input  logic        Clear,
  input  logic [15:0] DataLength,
  input  logic [15:0] GapLength,
  input  logic [23:0] TxLimit,
  input  logic [47:0] DstMac,
  input  logic [47:0] SrcMac,
  output logic        TxEn,
  output logic        TxErr,
  output logic [7:0]  TxData,
  output logic        Busy,
  output logic        FrameDone,
  output logic [23:0] TxCNT
);
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_GAP
  } state_t;

  state_t       state, nxt_state;
  logic [15:0]  cnt, nxt_cnt, last_cnt;
  logic [15:0]  pay_len, gap_len, pay_clamp, gap_clamp;
  logic [47:0]  dst_mac, src_mac;
  logic [23:0]  tx_limit, burst_cnt;
  logic [31:0]  crc, nxt_crc;
  logic [7:0]   nxt_data;
  logic         nxt_en, frame_end, frame_start, burst_done;
  logic [111:0] hdr;
  logic [3:0]   hdr_idx;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign pay_clamp = (DataLength < 16'(MIN_PAYLOAD)) ? 16'(MIN_PAYLOAD) :
                     (DataLength > 16'(MAX_PAYLOAD)) ? 16'(MAX_PAYLOAD) : DataLength;
  assign gap_clamp = (GapLength < 16'(MIN_GAP)) ? 16'(MIN_GAP) : GapLength;
  assign hdr        = {dst_mac, src_mac, pay_len};
  assign hdr_idx    = 4'd13 - nxt_cnt[3:0];
  assign burst_done = (tx_limit != '0) && (burst_cnt == tx_limit);

  // Next state: each non-idle state runs its counter to a terminal count
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 16'd1;
    last_cnt  = '0;
    case (state)
      S_PRE:   last_cnt = 16'(PREAMBLE_LEN - 1);
      S_HDR:   last_cnt = 16'd13;
      S_PAY:   last_cnt = pay_len - 16'd1;
      S_FCS:   last_cnt = 16'd3;
      S_GAP:   last_cnt = gap_len - 16'd1;
      default: last_cnt = '0;
    endcase
    if (state == S_IDLE) begin
      nxt_cnt = '0;
      if (SendEn) nxt_state = S_PRE;
    end else if (cnt == last_cnt) begin
      nxt_cnt = '0;
      case (state)
        S_PRE:   nxt_state = S_SFD;
        S_SFD:   nxt_state = S_HDR;
        S_HDR:   nxt_state = S_PAY;
        S_PAY:   nxt_state = S_FCS;
        S_FCS:   nxt_state = S_GAP;
        S_GAP:   nxt_state = (burst_done || Stop) ? S_IDLE : S_PRE;
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Byte to be driven next cycle, chosen from the state being entered;
  // the CRC advances on exactly the bytes that are loaded for HDR/PAY.
  always_comb begin
    nxt_en   = 1'b0;
    nxt_data = '0;
    nxt_crc  = crc;
    case (nxt_state)
      S_PRE: begin nxt_en = 1'b1; nxt_data = 8'h55; end
      S_SFD: begin nxt_en = 1'b1; nxt_data = 8'hD5; nxt_crc = '1; end
      S_HDR: begin
        nxt_en   = 1'b1;
        nxt_data = hdr[{hdr_idx, 3'b000} +: 8];
        nxt_crc  = crc32_byte(crc, nxt_data);
      end
      S_PAY: begin
        nxt_en   = 1'b1;
        nxt_data = nxt_cnt[7:0];
        nxt_crc  = crc32_byte(crc, nxt_data);
      end
      S_FCS: begin
        nxt_en   = 1'b1;
        nxt_data = ~(crc[{nxt_cnt[1:0], 3'b000} +: 8]);
      end
      default: ;
    endcase
  end

  assign frame_end   = (nxt_state == S_FCS) && (nxt_cnt == 16'd3);
  assign frame_start = (nxt_state == S_PRE) && (state != S_PRE);

  // State, registered GMII outputs, per-frame config latch and burst count
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      TxEn      <= 1'b0;
      TxErr     <= 1'b0;
      TxData    <= '0;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
      crc       <= '1;
      tx_limit  <= '0;
      burst_cnt <= '0;
      pay_len   <= 16'(MIN_PAYLOAD);
      gap_len   <= 16'(MIN_GAP);
      dst_mac   <= '0;
      src_mac   <= '0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      TxEn      <= nxt_en;
      TxErr     <= 1'b0;
      TxData    <= nxt_data;
      Busy      <= (nxt_state != S_IDLE);
      FrameDone <= frame_end;
      crc       <= nxt_crc;
      if (state == S_IDLE && SendEn) begin
        tx_limit  <= TxLimit;
        burst_cnt <= '0;
      end else if (frame_end) begin
        burst_cnt <= burst_cnt + 24'd1;
      end
      if (frame_start) begin
        pay_len <= pay_clamp;
        gap_len <= gap_clamp;
        dst_mac <= DstMac;
        src_mac <= SrcMac;
      end
    end
  end

  // Status frame counter: Clear beats a same-cycle increment, saturates
  always_ff @(posedge clk) begin
    if (rst || Clear)
      TxCNT <= '0;
    else if (frame_end && TxCNT != 24'hFFFFFF)
      TxCNT <= TxCNT + 24'd1;
  end
endmodule

// File: tb/tb_gmii_tx_frame_scheduler.sv
// Bench for gmii_tx_frame_scheduler: table rows plus random rows checked
// against a byte-level frame model, then hand sequences for Stop/Clear/rst.
module tb_gmii_tx_frame_scheduler;
  logic        clk = 1'b0;
  logic        rst, SendEn, Stop, Clear;
  logic [15:0] DataLength, GapLength;
  logic [23:0] TxLimit;
  logic [47:0] DstMac, SrcMac;
  logic        TxEn, TxErr, Busy, FrameDone;
  logic [7:0]  TxData;
  logic [23:0] TxCNT;

  gmii_tx_frame_scheduler dut (
    .clk(clk), .rst(rst), .SendEn(SendEn), .Stop(Stop), .Clear(Clear),
    .DataLength(DataLength), .GapLength(GapLength), .TxLimit(TxLimit),
    .DstMac(DstMac), .SrcMac(SrcMac), .TxEn(TxEn), .TxErr(TxErr),
    .TxData(TxData), .Busy(Busy), .FrameDone(FrameDone), .TxCNT(TxCNT)
  );

  always #4 clk = ~clk;

  typedef struct {
    int dl; int gl; int lim; int exp_len; int exp_gap;
  } vec_t;

  int          checks = 0, errors = 0;
  int          exp_cnt = 0;
  int          fd_idx;
  bit          err_seen;
  logic [31:0] crc_tbl [256];
  logic [7:0]  exp_q[$], got_q[$];
  vec_t        vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int clamp_len(input int dl);
    return dl < 46 ? 46 : (dl > 1500 ? 1500 : dl);
  endfunction

  // Reference frame as a byte list, CRC via a 256-entry lookup table
  task automatic build_exp(input int dl, input logic [47:0] d, input logic [47:0] s);
    int          L;
    logic [7:0]  body[$];
    logic [31:0] c;
    L = clamp_len(dl);
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 6; i++) body.push_back(d[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) body.push_back(s[47-8*i -: 8]);
    body.push_back(8'(L >> 8));
    body.push_back(8'(L));
    for (int i = 0; i < L; i++) body.push_back(8'(i));
    c = 32'hFFFFFFFF;
    foreach (body[i]) c = crc_tbl[8'(c ^ {24'd0, body[i]})] ^ (c >> 8);
    c = ~c;
    foreach (body[i]) exp_q.push_back(body[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8*k)));
  endtask

  task automatic start_burst(input int dl, input int gl, input int lim);
    DataLength = 16'(dl);
    GapLength  = 16'(gl);
    TxLimit    = 24'(lim);
    SendEn     = 1'b1;
    @(negedge clk);
    SendEn = 1'b0;
    check("start txen", TxEn, 1);
    check("start byte", TxData, 8'h55);
    check("start busy", Busy, 1);
  endtask

  // Collect one TxEn-high run; optionally raise Stop / pulse Clear at a byte index
  task automatic get_frame(input int stop_at, input int clear_at);
    int n = 0;
    got_q.delete();
    fd_idx   = -1;
    err_seen = 1'b0;
    while (!TxEn && n < 4000) begin @(negedge clk); n++; end
    if (!TxEn) begin check("frame start timeout", TxEn, 1); return; end
    while (TxEn && got_q.size() < 2000) begin
      got_q.push_back(TxData);
      if (FrameDone) fd_idx = got_q.size() - 1;
      if (TxErr) err_seen = 1'b1;
      if (got_q.size() == stop_at) Stop = 1'b1;
      Clear = (got_q.size() == clear_at);
      @(negedge clk);
    end
    Clear = 1'b0;
  endtask

  task automatic get_gap(input bit pulse_send, output int g);
    g = 0;
    while (!TxEn && Busy && g < 2000) begin
      SendEn = pulse_send && (g == 2);
      g++;
      @(negedge clk);
    end
    SendEn = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int exp_len);
    int mm = 0, first = -1;
    check({tag, " length"}, got_q.size(), exp_len);
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        mm++;
        if (first < 0) first = i;
      end
    if (first >= 0 && first < got_q.size())
      $display("  %s first differing byte %0d: got %02h want %02h", tag, first, got_q[first], exp_q[first]);
    check({tag, " byte mismatches"}, mm, 0);
    check({tag, " framedone index"}, fd_idx, got_q.size() - 1);
    check({tag, " txerr"}, err_seen, 0);
  endtask

  task automatic run_row(input string tag, input int dl, input int gl, input int lim,
                         input int exp_len, input int exp_gap);
    int g;
    DstMac = {16'($urandom()), $urandom()};
    SrcMac = {16'($urandom()), $urandom()};
    start_burst(dl, gl, lim);
    for (int f = 0; f < lim; f++) begin
      get_frame(-1, -1);
      build_exp(dl, DstMac, SrcMac);
      check_frame(tag, exp_len);
      exp_cnt++;
      get_gap(1'b0, g);
      check({tag, " gap"}, g, exp_gap);
    end
    check({tag, " busy end"}, Busy, 0);
    check({tag, " txcnt"}, TxCNT, exp_cnt);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, dl, gl;
    for (int n = 0; n < 256; n++) begin
      logic [31:0] c;
      c = 32'(n);
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_tbl[n] = c;
    end

    rst = 1'b1; SendEn = 1'b0; Stop = 1'b0; Clear = 1'b0;
    DataLength = 16'd46; GapLength = 16'd12; TxLimit = 24'd1;
    DstMac = 48'h0; SrcMac = 48'h0;
    repeat (3) @(negedge clk);
    check("reset txen", TxEn, 0);
    check("reset txerr", TxErr, 0);
    check("reset txdata", TxData, 0);
    check("reset busy", Busy, 0);
    check("reset framedone", FrameDone, 0);
    check("reset txcnt", TxCNT, 0);
    rst = 1'b0;
    @(negedge clk);

    // {DataLength, GapLength, TxLimit, TxEn-high cycles, gap cycles}
    vecs.push_back('{46,   12, 1, 72,   12});
    vecs.push_back('{10,    3, 1, 72,   12});
    vecs.push_back('{1600, 20, 1, 1526, 20});
    vecs.push_back('{100,  15, 2, 126,  15});
    vecs.push_back('{0,     0, 1, 72,   12});
    vecs.push_back('{1500, 12, 1, 1526, 12});
    vecs.push_back('{47,   13, 3, 73,   13});
    for (int r = 0; r < 4; r++) begin
      dl = $urandom_range(0, 300);
      gl = $urandom_range(0, 40);
      vecs.push_back('{dl, gl, $urandom_range(1, 3), 26 + clamp_len(dl), gl < 12 ? 12 : gl});
    end
    foreach (vecs[i])
      run_row($sformatf("row%0d", i), vecs[i].dl, vecs[i].gl, vecs[i].lim,
              vecs[i].exp_len, vecs[i].exp_gap);

    // Stop while idle does nothing
    Stop = 1'b1;
    repeat (5) @(negedge clk);
    check("idle stop busy", Busy, 0);
    check("idle stop txen", TxEn, 0);
    Stop = 1'b0;

    // Unlimited burst, Stop raised mid-payload of frame 3
    start_burst(46, 12, 0);
    for (int f = 0; f < 3; f++) begin
      get_frame(f == 2 ? 30 : -1, -1);
      build_exp(46, DstMac, SrcMac);
      check_frame($sformatf("stop f%0d", f), 72);
      exp_cnt++;
      get_gap(1'b0, g);
      check("stop gap", g, 12);
    end
    check("stop busy end", Busy, 0);
    check("stop txcnt", TxCNT, exp_cnt);
    Stop = 1'b0;

    // Clear on the counting edge, SendEn during GAP ignored
    start_burst(46, 12, 2);
    get_frame(-1, 71);
    build_exp(46, DstMac, SrcMac);
    check_frame("clr f1", 72);
    check("clear beats increment", TxCNT, 0);
    get_gap(1'b1, g);
    check("clr gap1", g, 12);
    get_frame(-1, -1);
    check_frame("clr f2", 72);
    get_gap(1'b0, g);
    check("clr gap2", g, 12);
    check("sendEn in gap ignored", Busy, 0);
    exp_cnt = 1;
    check("clr txcnt", TxCNT, exp_cnt);

    // rst in the middle of the header
    start_burst(46, 12, 1);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midframe rst txen", TxEn, 0);
    check("midframe rst busy", Busy, 0);
    check("midframe rst txcnt", TxCNT, 0);
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    run_row("post rst", 46, 12, 1, 72, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
